// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin arbiter sharing the MBINIT sideband TX message port between sub-step requesters.
// Tracks the sideband busy handshake and returns a one-cycle done pulse to the owner on busy fall.
module mbinit_sb_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int SB_MSG_WIDTH = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                            CLK,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                i_req_valid,
    input  logic [N_REQ*SB_MSG_WIDTH-1:0]   i_req_msg,
    input  logic                            i_Busy_SideBand,
    output logic [SB_MSG_WIDTH-1:0]         o_TX_SbMessage,
    output logic                            o_TX_valid,
    output logic [N_REQ-1:0]                o_grant,
    output logic [N_REQ-1:0]                o_done,
    output logic                            o_timeout_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gidx;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic               fall;

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [SB_MSG_WIDTH-1:0] sel_msg;
    logic [PTR_W-1:0]   next_ptr;

    assign fall     = busy_q & ~i_Busy_SideBand;
    assign next_ptr = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int unsigned k;
        sel_found = 1'b0;
        sel_idx   = '0;
        k         = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = (32'(rr_ptr) + i) % 32'(N_REQ);
            if (!sel_found && i_req_valid[k]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(k);
            end
        end
        sel_msg = i_req_msg[32'(sel_idx)*SB_MSG_WIDTH +: SB_MSG_WIDTH];
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            gidx           <= '0;
            cnt            <= '0;
            busy_q         <= 1'b0;
            o_TX_SbMessage <= '0;
            o_TX_valid     <= 1'b0;
            o_grant        <= '0;
            o_done         <= '0;
            o_timeout_err  <= 1'b0;
        end else begin
            busy_q        <= i_Busy_SideBand;
            o_done        <= '0;
            o_timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found && !i_Busy_SideBand) begin
                        state          <= SEND;
                        gidx           <= sel_idx;
                        cnt            <= '0;
                        o_TX_SbMessage <= sel_msg;
                        o_TX_valid     <= 1'b1;
                        o_grant        <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    end
                end
                SEND: begin
                    if (!i_req_valid[gidx]) begin
                        state          <= IDLE;
                        rr_ptr         <= next_ptr;
                        o_TX_valid     <= 1'b0;
                        o_TX_SbMessage <= '0;
                        o_grant        <= '0;
                    end else if (i_Busy_SideBand) begin
                        state          <= WAIT_DONE;
                        cnt            <= '0;
                        o_TX_valid     <= 1'b0;
                        o_TX_SbMessage <= '0;
                    end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        state          <= IDLE;
                        rr_ptr         <= next_ptr;
                        o_timeout_err  <= 1'b1;
                        o_TX_valid     <= 1'b0;
                        o_TX_SbMessage <= '0;
                        o_grant        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (fall) begin
                        state   <= IDLE;
                        rr_ptr  <= next_ptr;
                        o_done  <= o_grant;
                        o_grant <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
